mem_alu: RTL and testbench
==========================

MEM_ALU -- requirements
Module: mem_alu

Interface
REQ-001 Parameter N, default 32: data width of every storage word, read port and ALU operand/result.
REQ-002 clk  input  1  single clock; all storage writes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 addr1  input  5  read address for port 1 when re=1; write address when wr=1.
REQ-005 addr2  input  5  read address for port 2.
REQ-006 wdata  input  N  write data.
REQ-007 re  input  1  read enable for both read ports.
REQ-008 wr  input  1  write enable.
REQ-009 alucont  input  2  ALU operation select.
REQ-010 rdata1  output  N  read data, port 1.
REQ-011 rdata2  output  N  read data, port 2.
REQ-012 alu_y  output  N  ALU result computed from rdata1 (operand A) and rdata2 (operand B).

Function
REQ-013 Storage SHALL be 32 words of N bits, indexed 0..31; every 5-bit address is valid, with no out-of-range case.
REQ-014 Reads SHALL be combinational: re=1 gives rdata1=mem[addr1] and rdata2=mem[addr2] in the same cycle, with zero latency.
REQ-015 re=0 SHALL drive rdata1=rdata2=0, so alu_y follows the alucont operation applied to (0,0).
REQ-016 Writes: on the rising clk edge with wr=1 and rst high, mem[addr1] SHALL take wdata; wr=0 leaves storage unchanged.
REQ-017 Simultaneous re=1 and wr=1 to the same address SHALL return the old word on the read ports until the edge (no forwarding) unless MEM_ALU_BYPASS_EN is defined.
REQ-018 addr1=addr2 SHALL return the identical word on both ports.
REQ-019 ALU SHALL be purely combinational: 00 A+B, 01 A-B, 10 A AND B, 11 A OR B.
REQ-020 Add and subtract SHALL wrap modulo 2^N, with no carry or overflow output.
REQ-021 alu_y SHALL settle in the same cycle as rdata1/rdata2; there are no pipeline registers.

Reset
REQ-022 rst=0 SHALL clear all 32 words to 0 immediately, without waiting for a clock edge.
REQ-023 While rst=0, writes SHALL be ignored.
REQ-024 During and after reset, a read with re=1 SHALL return 0 until a location is written.
REQ-025 Reset asserted in the same cycle as a write SHALL win; the word stays 0.

Configuration
REQ-026 MEM_ALU_BYPASS_EN defined: when re=1, wr=1 and the read address equals addr1, that read port SHALL return wdata combinationally.
REQ-027 MEM_ALU_BYPASS_EN undefined: reads SHALL behave per REQ-017.

Structure
REQ-028 A shared package SHALL hold:
- ALU opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11
- DEPTH=32 and ADDR_W=5
REQ-029 The ALU SHALL be a separate sub-module named alu, parameterized by N, instantiated once inside mem_alu.

Verification
REQ-030 Reset: pulse rst=0, then read addresses 0 and 31 with re=1 -> rdata1=rdata2=0 and alu_y=0 with alucont=00.
REQ-031 Write/read: write 5 to addr 3 and 7 to addr 4, then re=1, addr1=3, addr2=4 -> alu_y per alucont:
- 00 -> 12
- 01 -> 0xFFFFFFFE
- 10 -> 5
- 11 -> 7
REQ-032 Wrap-around: write mem[1]=0xFFFFFFFF and mem[2]=1, read 1,2 with alucont=00 -> alu_y=0.
REQ-033 Collision: mem[6]=9; in one cycle set re=1, wr=1, addr1=6, wdata=20 -> before the edge rdata1=9 (20 with MEM_ALU_BYPASS_EN); after the edge rdata1=20.
REQ-034 Async reset mid-operation: assert rst=0 between clock edges after several writes -> rdata goes to 0 with no clock edge; a wr attempted during reset leaves the word 0.
REQ-035 re=0: any addresses -> rdata1=rdata2=0.

Source files
------------

// File: rtl/mem_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_alu_pkg
//  Description : Shared constants for the mem_alu block: storage geometry
//                and ALU operation encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_alu_pkg;

  // Storage geometry: 32 words, so every 5-bit address is in range.
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  // ALU operation select encodings (alucont).
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Purely combinational N-bit ALU. Add and subtract wrap
//                modulo 2^N; there is no carry or overflow output.
//  Revision    : 1.0 - initial release
//
//  Parameters  : N   - operand / result width
//  Ports       : a   in  [N-1:0] operand A
//                b   in  [N-1:0] operand B
//                op  in  [1:0]   operation select (ALU_ADD/SUB/AND/OR)
//                y   out [N-1:0] result
// ============================================================================
module alu
  import mem_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_alu
//  Description : 32 x N register storage with one write port, two
//                combinational read ports and a combinational ALU fed by
//                the two read ports. Reset clears every word immediately.
//  Revision    : 1.0 - initial release
//
//  Parameters  : N        - word / operand width (default 32)
//  Macro       : MEM_ALU_BYPASS_EN - when defined, a read whose address
//                matches the write address during a write returns wdata
//                combinationally instead of the stored word.
//  Ports       : clk      in  clock, writes on rising edge
//                rst      in  asynchronous active-low reset
//                addr1    in  [4:0]   read port 1 address / write address
//                addr2    in  [4:0]   read port 2 address
//                wdata    in  [N-1:0] write data
//                re       in  read enable (both ports)
//                wr       in  write enable
//                alucont  in  [1:0]   ALU operation select
//                rdata1   out [N-1:0] read data, port 1 (0 when re=0)
//                rdata2   out [N-1:0] read data, port 2 (0 when re=0)
//                alu_y    out [N-1:0] ALU result of rdata1 op rdata2
// ============================================================================
module mem_alu
  import mem_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [N-1:0]      wdata,
  input  logic              re,
  input  logic              wr,
  input  logic [1:0]        alucont,
  output logic [N-1:0]      rdata1,
  output logic [N-1:0]      rdata2,
  output logic [N-1:0]      alu_y
);

  // Packed so the whole array can be cleared in one assignment on reset.
  logic [DEPTH-1:0][N-1:0] mem_q;
  logic [DEPTH-1:0][N-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr) begin
      mem_d[addr1] = wdata;
    end
  end

  // Reset is asynchronous, so a write coinciding with reset is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports; disabled reads return zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (re) begin
      rdata1 = mem_q[addr1];
      rdata2 = mem_q[addr2];
`ifdef MEM_ALU_BYPASS_EN
      // Forward the word being written to any port reading that address.
      if (wr) begin
        rdata1 = wdata;
        if (addr2 == addr1) begin
          rdata2 = wdata;
        end
      end
`endif
    end
  end

  alu #(
    .N (N)
  ) u_alu (
    .a  (rdata1),
    .b  (rdata2),
    .op (alucont),
    .y  (alu_y)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_alu
//  Description : Directed self-checking bench for mem_alu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_alu;

  localparam int N = 32;

  logic          clk;
  logic          rst;
  logic [4:0]    addr1;
  logic [4:0]    addr2;
  logic [N-1:0]  wdata;
  logic          re;
  logic          wr;
  logic [1:0]    alucont;
  logic [N-1:0]  rdata1;
  logic [N-1:0]  rdata2;
  logic [N-1:0]  alu_y;

  int n_cmp;
  int n_err;

  mem_alu #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr1   (addr1),
    .addr2   (addr2),
    .wdata   (wdata),
    .re      (re),
    .wr      (wr),
    .alucont (alucont),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .alu_y   (alu_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write one cycle wide; inputs change 1 time unit after the edge.
  task automatic do_write(input logic [4:0] a, input logic [N-1:0] d);
    wr    = 1'b1;
    addr1 = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr    = 1'b0;
  endtask

  task automatic set_read(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [1:0] op);
    re      = 1'b1;
    addr1   = a1;
    addr2   = a2;
    alucont = op;
    #1;
  endtask

  logic [N-1:0] exp_coll;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b0;
    addr1   = '0;
    addr2   = '0;
    wdata   = '0;
    re      = 1'b0;
    wr      = 1'b0;
    alucont = 2'b00;

    // Reset state, read while reset held and after release.
    set_read(5'd0, 5'd31, 2'b00);
    check("rst_rd1_a0", rdata1, 32'd0);
    check("rst_rd2_a31", rdata2, 32'd0);
    check("rst_alu", alu_y, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_read(5'd0, 5'd31, 2'b00);
    check("post_rst_rd1", rdata1, 32'd0);
    check("post_rst_rd2", rdata2, 32'd0);

    // Write/read with each ALU operation.
    re = 1'b0;
    do_write(5'd3, 32'd5);
    do_write(5'd4, 32'd7);
    set_read(5'd3, 5'd4, 2'b00);
    check("rd1_a3", rdata1, 32'd5);
    check("rd2_a4", rdata2, 32'd7);
    check("alu_add", alu_y, 32'd12);
    set_read(5'd3, 5'd4, 2'b01);
    check("alu_sub", alu_y, 32'hFFFF_FFFE);
    set_read(5'd3, 5'd4, 2'b10);
    check("alu_and", alu_y, 32'd5);
    set_read(5'd3, 5'd4, 2'b11);
    check("alu_or", alu_y, 32'd7);
    set_read(5'd4, 5'd3, 2'b01);
    check("alu_sub_rev", alu_y, 32'd2);

    // Same address on both ports.
    set_read(5'd4, 5'd4, 2'b00);
    check("same_rd1", rdata1, 32'd7);
    check("same_rd2", rdata2, 32'd7);
    check("same_add", alu_y, 32'd14);

    // Wrap-around of add and subtract.
    re = 1'b0;
    do_write(5'd1, 32'hFFFF_FFFF);
    do_write(5'd2, 32'd1);
    set_read(5'd1, 5'd2, 2'b00);
    check("wrap_add", alu_y, 32'd0);
    set_read(5'd2, 5'd1, 2'b01);
    check("wrap_sub", alu_y, 32'd2);

    // Top address boundary.
    re = 1'b0;
    do_write(5'd31, 32'hA5A5_0F0F);
    set_read(5'd31, 5'd0, 2'b11);
    check("rd_a31", rdata1, 32'hA5A5_0F0F);
    check("or_a31", alu_y, 32'hA5A5_0F0F);

    // Read/write collision on the same address.
    re = 1'b0;
    do_write(5'd6, 32'd9);
`ifdef MEM_ALU_BYPASS_EN
    exp_coll = 32'd20;
`else
    exp_coll = 32'd9;
`endif
    re      = 1'b1;
    wr      = 1'b1;
    addr1   = 5'd6;
    addr2   = 5'd6;
    wdata   = 32'd20;
    alucont = 2'b00;
    #1;
    check("coll_pre_rd1", rdata1, exp_coll);
    check("coll_pre_rd2", rdata2, exp_coll);
    @(posedge clk);
    #1;
    wr = 1'b0;
    #1;
    check("coll_post_rd1", rdata1, 32'd20);
    check("coll_post_add", alu_y, 32'd40);

    // Read disable forces zero regardless of address and operation.
    re      = 1'b0;
    addr1   = 5'd3;
    addr2   = 5'd4;
    alucont = 2'b11;
    #1;
    check("re0_rd1", rdata1, 32'd0);
    check("re0_rd2", rdata2, 32'd0);
    check("re0_alu_or", alu_y, 32'd0);
    alucont = 2'b01;
    #1;
    check("re0_alu_sub", alu_y, 32'd0);

    // Asynchronous reset between clock edges.
    set_read(5'd3, 5'd4, 2'b00);
    check("pre_async_rd1", rdata1, 32'd5);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rd1", rdata1, 32'd0);
    check("async_rd2", rdata2, 32'd0);
    check("async_alu", alu_y, 32'd0);
    // Write attempted while reset is held must not land.
    re = 1'b0;
    do_write(5'd5, 32'h0000_0055);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_read(5'd5, 5'd31, 2'b11);
    check("rst_wr_blocked", rdata1, 32'd0);
    check("rst_cleared_a31", rdata2, 32'd0);

    // Storage usable again after reset.
    re = 1'b0;
    do_write(5'd5, 32'h0000_0055);
    set_read(5'd5, 5'd5, 2'b10);
    check("after_rst_wr", rdata1, 32'h0000_0055);
    check("after_rst_and", alu_y, 32'h0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
